// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_stage
// Brief    : Registered immediate-generation stage. Classifies the instruction
//            format from the opcode, builds the extended immediate, flags
//            illegal encodings and computes the PC-relative target. Valid/ready
//            on both sides with a 2-entry (out + skid) buffer.
// Revision : 1.0 - initial release
// ============================================================================
module imm_decode_stage #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // Buffered entry layout: {illegal, fmt, imm, target}
  localparam int EW = 2 * XLEN + 4;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic            w_shift;
  logic [63:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_z, w_imm_sh;
  logic [63:0]     w_imm64;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic            w_pcrel;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_target;
  logic [EW-1:0]   w_entry;

  logic            out_valid_q, out_valid_d;
  logic [EW-1:0]   out_data_q, out_data_d;
  logic            skid_valid_q, skid_valid_d;
  logic [EW-1:0]   skid_data_q, skid_data_d;
  logic            w_accept;
  logic            w_out_fire;

  assign w_opcode = in_inst[6:0];
  assign w_funct3 = in_inst[14:12];
  assign w_shift  = (w_funct3[1:0] == 2'b01);  // funct3 = 001 (SLLI) or 101 (SRLI/SRAI)

  // All candidate immediates are built at 64 bits and truncated to XLEN once
  assign w_imm_i  = {{52{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b  = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u  = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
  assign w_imm_j  = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign w_imm_z  = {59'b0, in_inst[19:15]};
  // 6-bit shamt only exists for the full-width OP-IMM shifts on RV64
  assign w_imm_sh = ((XLEN == 64) && (w_opcode == OPC_OP_IMM)) ? {58'b0, in_inst[25:20]}
                                                                : {59'b0, in_inst[24:20]};

  // Format classification, illegal detection and immediate selection
  always_comb begin
    w_fmt     = FMT_NONE;
    w_illegal = 1'b0;
    w_pcrel   = 1'b0;
    w_imm64   = '0;
    case (w_opcode)
      OPC_LOAD, OPC_JALR: w_fmt = FMT_I;
      OPC_OP_IMM:         w_fmt = w_shift ? FMT_SH : FMT_I;
      OPC_OP_IMM_32: begin
        if (XLEN == 64) w_fmt = w_shift ? FMT_SH : FMT_I;
        else            w_illegal = 1'b1;
      end
      OPC_SYSTEM:         w_fmt = w_funct3[2] ? FMT_Z : FMT_I;
      OPC_STORE:          w_fmt = FMT_S;
      OPC_BRANCH: begin
        w_fmt   = FMT_B;
        w_pcrel = 1'b1;
      end
      OPC_LUI:            w_fmt = FMT_U;
      OPC_AUIPC: begin
        w_fmt   = FMT_U;
        w_pcrel = 1'b1;
      end
      OPC_JAL: begin
        w_fmt   = FMT_J;
        w_pcrel = 1'b1;
      end
      OPC_OP:             w_fmt = FMT_NONE;
      OPC_OP_32: begin
        if (XLEN != 64) w_illegal = 1'b1;
      end
      default:            w_illegal = 1'b1;
    endcase
    // Every recognised opcode ends in 2'b11, so compressed encodings land in default
    if (w_illegal) begin
      w_fmt   = FMT_NONE;
      w_pcrel = 1'b0;
    end
    case (w_fmt)
      FMT_I:   w_imm64 = w_imm_i;
      FMT_S:   w_imm64 = w_imm_s;
      FMT_B:   w_imm64 = w_imm_b;
      FMT_U:   w_imm64 = w_imm_u;
      FMT_J:   w_imm64 = w_imm_j;
      FMT_Z:   w_imm64 = w_imm_z;
      FMT_SH:  w_imm64 = w_imm_sh;
      default: w_imm64 = '0;
    endcase
  end

  assign w_imm    = w_imm64[XLEN-1:0];
  assign w_target = in_pc + (w_pcrel ? w_imm : XLEN'(4));
  assign w_entry  = {w_illegal, w_fmt, w_imm, w_target};

  // in_ready comes straight from the skid flop, so it never depends on out_ready
  assign in_ready   = ~skid_valid_q;
  assign w_accept   = in_valid & in_ready;
  assign w_out_fire = out_valid_q & out_ready;

  // Buffer control: flush first, then skid drain, direct load, skid load, drain
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_out_fire && skid_valid_q) begin
      out_data_d   = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (w_accept && (!out_valid_q || out_ready)) begin
      out_valid_d  = 1'b1;
      out_data_d   = w_entry;
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = w_entry;
    end else if (w_out_fire) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_illegal = out_data_q[EW-1];
  assign out_fmt     = out_data_q[EW-2 -: 3];
  assign out_imm     = out_data_q[2*XLEN-1 -: XLEN];
  assign out_target  = out_data_q[XLEN-1:0];

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_decode_stage
// Brief    : Self-checking bench driving an XLEN=64 and an XLEN=32 instance in
//            lockstep with directed cases and a randomized scoreboard run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_decode_stage;

  typedef struct packed {
    logic        ill;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [63:0] tgt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64, out_target64;
  logic [2:0]  out_fmt64;
  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_target32;
  logic [2:0]  out_fmt32;
  logic [31:0] in_pc32;

  int checks = 0;
  int failures = 0;
  exp_t q64[$];
  exp_t q32[$];
  logic [6:0] ops [14];

  assign in_pc32 = in_pc[31:0];

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64), .ILEN(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_target(out_target64), .out_illegal(out_illegal64));

  imm_decode_stage #(.XLEN(32), .ILEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_pc(in_pc32), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_target(out_target32), .out_illegal(out_illegal32));

  // Reference: decode by instruction-set rules using signed integer arithmetic
  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input bit x64);
    exp_t e;
    longint s, si, ss, su, sg;
    logic [63:0] v;
    bit pcrel;
    s  = longint'($signed(inst));
    si = s >>> 20;
    ss = s >>> 25;
    su = s >>> 12;
    sg = s >>> 31;
    e = '0; v = '0; pcrel = 0;
    case (inst[6:0])
      7'h03, 7'h67: begin e.fmt = 3'd1; v = si; end
      7'h13, 7'h1B: begin
        if (inst[6:0] == 7'h1B && !x64) e.ill = 1'b1;
        else if (inst[13:12] == 2'b01) begin
          e.fmt = 3'd7;
          v = (x64 && inst[6:0] == 7'h13) ? 64'(inst[25:20]) : 64'(inst[24:20]);
        end else begin e.fmt = 3'd1; v = si; end
      end
      7'h73: if (inst[14]) begin e.fmt = 3'd6; v = 64'(inst[19:15]); end
             else begin e.fmt = 3'd1; v = si; end
      7'h23: begin e.fmt = 3'd2; v = ss * 32 + inst[11:7]; end
      7'h63: begin e.fmt = 3'd3; pcrel = 1;
                   v = sg * 4096 + inst[7] * 2048 + inst[30:25] * 32 + inst[11:8] * 2; end
      7'h37: begin e.fmt = 3'd4; v = su * 4096; end
      7'h17: begin e.fmt = 3'd4; v = su * 4096; pcrel = 1; end
      7'h6F: begin e.fmt = 3'd5; pcrel = 1;
                   v = sg * 1048576 + inst[19:12] * 4096 + inst[20] * 2048 + inst[30:21] * 2; end
      7'h33: e.fmt = 3'd0;
      7'h3B: if (!x64) e.ill = 1'b1;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.fmt = 3'd0; v = '0; pcrel = 0; end
    e.imm = v;
    e.tgt = pc + (pcrel ? v : 64'd4);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare both instances' out_* against the model of a given input
  task automatic chk_out(input string tag, input logic [31:0] inst, input logic [63:0] pc);
    exp_t e, f;
    e = model(inst, pc, 1'b1);
    f = model(inst, {32'h0, pc[31:0]}, 1'b0);
    chk({tag, ".v64"}, 64'(out_valid64), 64'd1);
    chk({tag, ".imm64"}, out_imm64, e.imm);
    chk({tag, ".fmt64"}, 64'(out_fmt64), 64'(e.fmt));
    chk({tag, ".tgt64"}, out_target64, e.tgt);
    chk({tag, ".ill64"}, 64'(out_illegal64), 64'(e.ill));
    chk({tag, ".imm32"}, 64'(out_imm32), 64'(f.imm[31:0]));
    chk({tag, ".fmt32"}, 64'(out_fmt32), 64'(f.fmt));
    chk({tag, ".tgt32"}, 64'(out_target32), 64'(f.tgt[31:0]));
    chk({tag, ".ill32"}, 64'(out_illegal32), 64'(f.ill));
  endtask

  task automatic xfer(input logic [31:0] inst, input logic [63:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_out("xfer", inst, pc);
  endtask

  // One random cycle: drive at posedge+1, score the handshakes at the negedge
  task automatic rand_cycle(input bit drain);
    logic [31:0] inst;
    exp_t ex;
    inst = $urandom;
    if ($urandom_range(0, 7) != 0) inst[6:0] = ops[$urandom_range(0, 13)];
    in_inst   = inst;
    in_pc     = ($urandom_range(0, 3) == 0) ? {32'hFFFFFFFF, 32'hFFFFFF00 | 32'($urandom_range(0, 255))}
                                            : {$urandom, $urandom};
    in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
    out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
    flush     = drain ? 1'b0 : ($urandom_range(0, 31) == 0);
    @(negedge clk);
    chk("rnd.v64", 64'(out_valid64), 64'(q64.size() != 0));
    chk("rnd.rdy64", 64'(in_ready64), 64'(q64.size() < 2));
    chk("rnd.rdy32", 64'(in_ready32), 64'(q32.size() < 2));
    if (out_valid64 && q64.size() != 0) begin
      chk("rnd.imm64", out_imm64, q64[0].imm);
      chk("rnd.tgt64", out_target64, q64[0].tgt);
      chk("rnd.fi64", 64'({out_illegal64, out_fmt64}), 64'({q64[0].ill, q64[0].fmt}));
    end
    if (out_valid32 && q32.size() != 0) begin
      chk("rnd.imm32", 64'(out_imm32), 64'(q32[0].imm[31:0]));
      chk("rnd.tgt32", 64'(out_target32), 64'(q32[0].tgt[31:0]));
      chk("rnd.fi32", 64'({out_illegal32, out_fmt32}), 64'({q32[0].ill, q32[0].fmt}));
    end
    if (flush) begin
      q64.delete();
      q32.delete();
    end else begin
      if (out_valid64 && out_ready && q64.size() != 0) void'(q64.pop_front());
      if (out_valid32 && out_ready && q32.size() != 0) void'(q32.pop_front());
      if (in_valid && in_ready64) q64.push_back(model(in_inst, in_pc, 1'b1));
      if (in_valid && in_ready32) q32.push_back(model(in_inst, {32'h0, in_pc[31:0]}, 1'b0));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h12};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.v", 64'(out_valid64), 64'd0);
    chk("rst.rdy", 64'(in_ready64), 64'd1);
    chk("rst.imm", out_imm64, 64'd0);
    chk("rst.tgt", out_target64, 64'd0);
    chk("rst.fi", 64'({out_illegal64, out_fmt64}), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.idle", 64'(out_valid64), 64'd0);

    // Directed decodes with literal expectations
    xfer(32'hFE000EE3, 64'h1000);
    chk("beq.fmt", 64'(out_fmt64), 64'd3);
    chk("beq.imm", out_imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("beq.tgt", out_target64, 64'hFFC);
    chk("beq.ill", 64'(out_illegal64), 64'd0);
    xfer(32'h800000EF, 64'h80000000);
    chk("jal.imm", out_imm64, 64'hFFFFFFFFFFF00000);
    chk("jal.tgt", out_target64, 64'h7FF00000);
    xfer(32'h12345037, 64'h80000004);
    chk("lui.fmt", 64'(out_fmt64), 64'd4);
    chk("lui.imm", out_imm64, 64'h12345000);
    chk("lui.tgt", out_target64, 64'h80000008);
    xfer(32'h03F51513, 64'h100);
    chk("slli.fmt", 64'(out_fmt64), 64'd7);
    chk("slli.imm", out_imm64, 64'd63);
    chk("slli.imm32", 64'(out_imm32), 64'd31);
    xfer(32'h3401F073, 64'h104);
    chk("csr.fmt", 64'(out_fmt64), 64'd6);
    chk("csr.imm", out_imm64, 64'd3);
    xfer(32'h00000000, 64'h108);
    chk("zero.ill", 64'(out_illegal64), 64'd1);
    chk("zero.imm", out_imm64, 64'd0);
    xfer(32'h0005051B, 64'h200);
    chk("addiw.ill32", 64'(out_illegal32), 64'd1);
    chk("addiw.ill64", 64'(out_illegal64), 64'd0);
    xfer(32'h0080006F, 64'hFFFFFFFC);
    chk("wrap.tgt32", 64'(out_target32), 64'd4);
    chk("wrap.tgt64", out_target64, 64'h100000004);
    tick();
    chk("drain.v", 64'(out_valid64), 64'd0);

    // Back-pressure: A to out, B to skid, C held by the source
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 64'h2000;
    tick();
    chk("bp.rdyA", 64'(in_ready64), 64'd1);
    chk_out("bp.A", 32'hFE000EE3, 64'h2000);
    in_inst = 32'h800000EF; in_pc = 64'h2004;
    tick();
    chk("bp.rdyB", 64'(in_ready64), 64'd0);
    chk_out("bp.holdA", 32'hFE000EE3, 64'h2000);
    in_inst = 32'h12345037; in_pc = 64'h2008;
    tick();
    chk("bp.rdyC", 64'(in_ready64), 64'd0);
    chk_out("bp.stallA", 32'hFE000EE3, 64'h2000);
    out_ready = 1'b1;
    tick();
    chk_out("bp.B", 32'h800000EF, 64'h2004);
    chk("bp.rdy1", 64'(in_ready64), 64'd1);
    tick();
    chk_out("bp.C", 32'h12345037, 64'h2008);
    for (int i = 0; i < 4; i++) begin
      in_inst = 32'h00A00093 + 32'(i << 20); in_pc = 64'h3000 + 64'(4 * i);
      tick();
      chk_out("tput", 32'h00A00093 + 32'(i << 20), 64'h3000 + 64'(4 * i));
      chk("tput.rdy", 64'(in_ready64), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("bp.empty", 64'(out_valid64), 64'd0);

    // Flush with out and skid full and a same-cycle input
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 64'h4000;
    tick();
    in_inst = 32'h800000EF;
    tick();
    flush = 1'b1; in_inst = 32'h12345037;
    tick();
    chk("fl.v", 64'(out_valid64), 64'd0);
    chk("fl.rdy", 64'(in_ready64), 64'd1);
    tick();
    chk("fl.v2", 64'(out_valid64), 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl.gone", 64'(out_valid64), 64'd0);

    // Asynchronous reset between edges with data buffered
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h800000EF; in_pc = 64'h5000;
    tick();
    in_inst = 32'hFE000EE3;
    tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.v", 64'(out_valid64), 64'd0);
    chk("arst.imm", out_imm64, 64'd0);
    chk("arst.rdy", 64'(in_ready64), 64'd1);
    #2 rst_n = 1'b1;
    tick();
    chk("arst.after", 64'(out_valid64), 64'd0);

    // Randomized run against the scoreboard, then drain
    for (int i = 0; i < 600; i++) rand_cycle(1'b0);
    for (int i = 0; i < 4; i++) rand_cycle(1'b1);
    chk("end.q", 64'(q64.size()), 64'd0);
    chk("end.v", 64'(out_valid64), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
